memory_access: RTL and testbench

Pipeline MEM stage, directly downstream of the execute stage. Consumes the registered ALU result as a load/store address or as pass-through write-back data. Drives a single-outstanding request/ready data-memory port. Handles byte/half/word lanes and sign extension, and presents a registered result to write-back. Stalls upstream while a memory access is in flight.

---
 rtl/memory_access.sv | 210 +++++++++++++++++++++
 tb/tb_memory_access.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// memory_access: pipeline MEM stage with a single-outstanding req/ready data port.
// Optional DMEM_TIMEOUT_EN adds a WAIT-state watchdog that retires with bus_error.
module memory_access #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RD_W           = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     alu_result,
  input  logic [31:0]     store_data,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_reg_write,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [31:0]     dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [31:0]     dmem_wdata,
  input  logic            dmem_ready,
  input  logic [31:0]     dmem_rdata,
  output logic            wb_valid,
  output logic [31:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_reg_write,
  output logic            misaligned,
  output logic            bus_error
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]      state;
  logic            mem_op;
  logic            is_byte;
  logic            is_half;
  logic            is_word;
  logic            mis;
  logic [1:0]      off;
  logic [3:0]      be_n;
  logic [31:0]     wd_n;

  logic            l_load;
  logic            l_byte;
  logic            l_half;
  logic            l_uns;
  logic [1:0]      l_off;
  logic [RD_W-1:0] l_rd;
  logic            l_rw;

  logic [31:0]     rd_sh;
  logic [31:0]     ld_data;
  logic            to_hit;

  // Request decode from the execute-stage bundle
  always_comb begin
    mem_op  = in_valid & (mem_read | mem_write);
    off     = alu_result[1:0];
    is_byte = (funct3[1:0] == 2'b00);
    is_half = (funct3[1:0] == 2'b01);
    is_word = !is_byte && !is_half;
    mis     = (is_half & off[0]) | (is_word & (off != 2'b00));
    be_n    = 4'b1111;
    wd_n    = store_data;
    unique case (1'b1)
      is_byte: begin
        be_n = 4'b0001 << off;
        wd_n = {4{store_data[7:0]}};
      end
      is_half: begin
        be_n = 4'b0011 << off;
        wd_n = {2{store_data[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = store_data;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returned word
  always_comb begin
    rd_sh   = dmem_rdata >> {l_off, 3'b000};
    ld_data = rd_sh;
    unique case (1'b1)
      l_byte:  ld_data = l_uns ? {24'b0, rd_sh[7:0]}
                               : {{24{rd_sh[7]}}, rd_sh[7:0]};
      l_half:  ld_data = l_uns ? {16'b0, rd_sh[15:0]}
                               : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: ld_data = rd_sh;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  logic [15:0] to_cnt;

  assign to_hit = (state == S_WAIT) && !dmem_ready &&
                  (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts unanswered WAIT cycles, idle value is zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state != S_WAIT || to_hit) begin
      to_cnt <= '0;
    end else if (!dmem_ready) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  // Bus error pulses alongside the timeout retirement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_error <= 1'b0;
    end else begin
      bus_error <= to_hit;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign bus_error = 1'b0;
`endif

  assign mem_stall = ((state == S_IDLE) && mem_op && !mis) ||
                     ((state == S_WAIT) && !dmem_ready && !to_hit);

  // Stage control, memory request and write-back registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      l_load       <= 1'b0;
      l_byte       <= 1'b0;
      l_half       <= 1'b0;
      l_uns        <= 1'b0;
      l_off        <= '0;
      l_rd         <= '0;
      l_rw         <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      misaligned   <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid && !mem_op) begin
            wb_valid     <= 1'b1;
            wb_data      <= alu_result;
            wb_rd        <= in_rd;
            wb_reg_write <= in_reg_write;
          end else if (mem_op && mis) begin
            wb_valid     <= 1'b1;
            misaligned   <= 1'b1;
            wb_data      <= alu_result;
            wb_rd        <= in_rd;
            wb_reg_write <= 1'b0;
          end else if (mem_op) begin
            state      <= S_WAIT;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_be    <= be_n;
            dmem_wdata <= wd_n;
            l_load     <= !mem_write;
            l_byte     <= is_byte;
            l_half     <= is_half;
            l_uns      <= funct3[2];
            l_off      <= off;
            l_rd       <= in_rd;
            l_rw       <= in_reg_write;
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            state    <= S_IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= l_rd;
            if (l_load) begin
              wb_data      <= ld_data;
              wb_reg_write <= l_rw;
            end else begin
              wb_data      <= '0;
              wb_reg_write <= 1'b0;
            end
          end else if (to_hit) begin
            state        <= S_IDLE;
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_rd        <= l_rd;
            wb_data      <= dmem_addr;
            wb_reg_write <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed vector table plus reset / timeout sequences.
// Build with +define+DMEM_TIMEOUT_EN to exercise the watchdog path.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        misaligned;
  logic        bus_error;

  int n_cmp = 0;
  int n_fail = 0;

  memory_access #(.TIMEOUT_CYCLES(4), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .alu_result(alu_result), .store_data(store_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .misaligned(misaligned),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rop;
    logic        wop;
    logic        rw;
    logic [2:0]  f3;
    int          dly;
    logic [31:0] rdata;
    logic [31:0] e_data;
    logic        e_rw;
    logic        e_mis;
    logic        e_req;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata;
    int          e_stall;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int waited;
    int stalls;
    bit done;
    bit req_seen;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    logic [31:0] held;
    string pfx;
    pfx = $sformatf("v%0d", idx);
    waited = 0;
    stalls = 0;
    done = 0;
    req_seen = 0;
    c_addr = '0;
    c_wdata = '0;
    c_be = '0;
    c_we = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    alu_result = v.alu;
    store_data = v.sd;
    in_rd = v.rd;
    mem_read = v.rop;
    mem_write = v.wop;
    in_reg_write = v.rw;
    funct3 = v.f3;
    dmem_ready = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (dmem_req) begin
        req_seen = 1;
        c_addr = dmem_addr;
        c_wdata = dmem_wdata;
        c_be = dmem_be;
        c_we = dmem_we;
        if (waited == v.dly) begin
          dmem_ready = 1'b1;
          dmem_rdata = v.rdata;
        end else begin
          dmem_ready = 1'b0;
          dmem_rdata = 32'hxxxx_xxxx;
        end
        waited++;
      end
      #1;
      if (mem_stall) stalls++;
      @(posedge clk);
      #1;
      if (wb_valid) done = 1;
      else @(negedge clk);
    end
    chk({pfx, " retired"}, 32'(done), 32'd1);
    chk({pfx, " wb_data"}, wb_data, v.e_data);
    chk({pfx, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
    chk({pfx, " wb_reg_write"}, 32'(wb_reg_write), 32'(v.e_rw));
    chk({pfx, " misaligned"}, 32'(misaligned), 32'(v.e_mis));
    chk({pfx, " bus_error"}, 32'(bus_error), 32'd0);
    chk({pfx, " stall_cycles"}, 32'(stalls), 32'(v.e_stall));
    chk({pfx, " req_seen"}, 32'(req_seen), 32'(v.e_req));
    if (v.e_req) begin
      chk({pfx, " dmem_addr"}, c_addr, v.e_addr);
      chk({pfx, " dmem_be"}, 32'(c_be), 32'(v.e_be));
      chk({pfx, " dmem_we"}, 32'(c_we), 32'(v.e_we));
      if (v.e_we) chk({pfx, " dmem_wdata"}, c_wdata, v.e_wdata);
    end
    held = wb_data;
    @(negedge clk);
    in_valid = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk({pfx, " wb_valid_pulse"}, 32'(wb_valid), 32'd0);
    chk({pfx, " wb_data_hold"}, wb_data, held);
    chk({pfx, " req_idle"}, 32'(dmem_req), 32'd0);
  endtask

  initial begin
    int stalls;
    int hit_at;
    vec_t alu_v;

    //      alu           sd            rd  r  w  rw f3    d rdata        e_data        erw mis req addr         be       we wdata        st
    vt[0]  = '{32'h1234,     32'h0,        5, 0, 0, 1, 3'b000, 0, 32'h0,        32'h1234,     1, 0, 0, 32'h0,      4'b0000, 0, 32'h0,        0};
    vt[1]  = '{32'h103,      32'h0,        7, 1, 0, 1, 3'b000, 3, 32'h80FF_0000, 32'hFFFF_FF80, 1, 0, 1, 32'h100,    4'b1000, 0, 32'h0,        4};
    vt[2]  = '{32'h103,      32'h0,        8, 1, 0, 1, 3'b100, 3, 32'h80FF_0000, 32'h0000_0080, 1, 0, 1, 32'h100,    4'b1000, 0, 32'h0,        4};
    vt[3]  = '{32'h202,      32'hDEAD_BEEF, 0, 0, 1, 0, 3'b001, 0, 32'h0,        32'h0,        0, 0, 1, 32'h200,    4'b1100, 1, 32'hBEEF_BEEF, 1};
    vt[4]  = '{32'h301,      32'h0,        1, 1, 0, 1, 3'b010, 0, 32'h0,        32'h301,      0, 1, 0, 32'h0,      4'b0000, 0, 32'h0,        0};
    vt[5]  = '{32'h106,      32'h0,        2, 1, 0, 1, 3'b001, 1, 32'h8001_1234, 32'hFFFF_8001, 1, 0, 1, 32'h104,    4'b1100, 0, 32'h0,        2};
    vt[6]  = '{32'h102,      32'h0,        3, 1, 0, 1, 3'b101, 0, 32'h8001_1234, 32'h0000_8001, 1, 0, 1, 32'h100,    4'b1100, 0, 32'h0,        1};
    vt[7]  = '{32'h40,       32'h0,        9, 1, 0, 1, 3'b010, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0, 1, 32'h40,     4'b1111, 0, 32'h0,        3};
    vt[8]  = '{32'h11,       32'h1234_5678, 0, 0, 1, 0, 3'b000, 0, 32'h0,        32'h0,        0, 0, 1, 32'h10,     4'b0010, 1, 32'h7878_7878, 1};
    vt[9]  = '{32'h44,       32'hA5A5_5A5A, 0, 0, 1, 0, 3'b010, 1, 32'h0,        32'h0,        0, 0, 1, 32'h44,     4'b1111, 1, 32'hA5A5_5A5A, 2};
    vt[10] = '{32'h203,      32'h1,        0, 0, 1, 0, 3'b001, 0, 32'h0,        32'h203,      0, 1, 0, 32'h0,      4'b0000, 0, 32'h0,        0};
    vt[11] = '{32'h8,        32'h11,       4, 1, 1, 1, 3'b010, 0, 32'hFFFF_FFFF, 32'h0,        0, 0, 1, 32'h8,      4'b1111, 1, 32'h11,       1};
    vt[12] = '{32'h24,       32'h0,        6, 1, 0, 1, 3'b011, 0, 32'h8000_0000, 32'h8000_0000, 1, 0, 1, 32'h24,     4'b1111, 0, 32'h0,        1};
    vt[13] = '{32'h100,      32'h0,        10, 1, 0, 1, 3'b000, 0, 32'h0000_007F, 32'h0000_007F, 1, 0, 1, 32'h100,    4'b0001, 0, 32'h0,        1};
    vt[14] = '{32'h50,       32'h0,        0, 1, 0, 0, 3'b010, 0, 32'h5555,     32'h5555,     0, 0, 1, 32'h50,     4'b1111, 0, 32'h0,        1};

    #2;
    chk("reset wb_valid", 32'(wb_valid), 32'd0);
    chk("reset dmem_req", 32'(dmem_req), 32'd0);
    chk("reset wb_data", wb_data, 32'h0);
    chk("reset mem_stall", 32'(mem_stall), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Idle cycle with a spurious ready must do nothing
    @(negedge clk);
    dmem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("idle ready wb_valid", 32'(wb_valid), 32'd0);
    chk("idle ready dmem_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    dmem_ready = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(i, vt[i]);

    // Asynchronous reset while a load sits in WAIT
    @(negedge clk);
    in_valid = 1'b1;
    alu_result = 32'h88;
    mem_read = 1'b1;
    funct3 = 3'b010;
    in_rd = 5'd12;
    in_reg_write = 1'b1;
    @(posedge clk);
    #1;
    chk("arst pre dmem_req", 32'(dmem_req), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    in_valid = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("arst dmem_req", 32'(dmem_req), 32'd0);
    chk("arst dmem_addr", dmem_addr, 32'h0);
    chk("arst dmem_be", 32'(dmem_be), 32'd0);
    chk("arst wb_data", wb_data, 32'h0);
    chk("arst wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("arst mem_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    alu_v = vt[0];
    alu_v.alu = 32'h5A5A;
    alu_v.e_data = 32'h5A5A;
    alu_v.rd = 5'd17;
    run_vec(100, alu_v);

    // Memory never answers
    @(negedge clk);
    in_valid = 1'b1;
    alu_result = 32'h60;
    mem_read = 1'b1;
    mem_write = 1'b0;
    funct3 = 3'b010;
    in_rd = 5'd3;
    in_reg_write = 1'b1;
    dmem_ready = 1'b0;
    stalls = 0;
    hit_at = -1;
    for (int c = 0; c < 30 && hit_at < 0; c++) begin
      #1;
      if (mem_stall) stalls++;
      @(posedge clk);
      #1;
      if (wb_valid) hit_at = c;
      @(negedge clk);
    end
`ifdef DMEM_TIMEOUT_EN
    chk("to cycle", 32'(hit_at), 32'd4);
    chk("to stall_cycles", 32'(stalls), 32'd4);
    chk("to bus_error", 32'(bus_error), 32'd1);
    chk("to wb_data", wb_data, 32'h60);
    chk("to wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("to dmem_req", 32'(dmem_req), 32'd0);
    in_valid = 1'b0;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    chk("to bus_error pulse", 32'(bus_error), 32'd0);
`else
    chk("hang no retire", 32'(hit_at), 32'hFFFF_FFFF);
    chk("hang stall", 32'(mem_stall), 32'd1);
    chk("hang stall_cycles", 32'(stalls), 32'd30);
    chk("hang dmem_req", 32'(dmem_req), 32'd1);
    chk("hang bus_error", 32'(bus_error), 32'd0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    #1;
    chk("hang ready stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("hang late wb_valid", 32'(wb_valid), 32'd1);
    chk("hang late wb_data", wb_data, 32'h0BAD_F00D);
    @(negedge clk);
    in_valid = 1'b0;
    mem_read = 1'b0;
    dmem_ready = 1'b0;
`endif
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
